// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: restoring radix-2 divider with pipeline stall/flush handshake.
// Produces hi=remainder, lo=quotient; divide-by-zero returns lo=all-ones, hi=dividend.
module div_sequencer #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic        ready,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        DIVZERO = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t       state, state_next;
    logic [5:0]   cnt;
    logic [W-1:0] rem, quo, dvs, a_raw;
    logic         neg_q, neg_r;
    logic         accept;

    logic [W:0]   rem_shift, trial;
    logic         q_bit;
    logic [W-1:0] rem_step, quo_step, q_fix, r_fix;

    // One restoring step plus the sign fix-up applied when the last step lands in DONE.
    always_comb begin
        rem_shift = {rem, quo[W-1]};
        trial     = rem_shift - {1'b0, dvs};
        q_bit     = ~trial[W];
        rem_step  = q_bit ? trial[W-1:0] : rem_shift[W-1:0];
        quo_step  = {quo[W-2:0], q_bit};
        q_fix     = neg_q ? W'(-quo_step) : quo_step;
        r_fix     = neg_r ? W'(-rem_step) : rem_step;
    end

    // Next-state and the combinational stall that freezes the pipeline in the accept cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = (b == '0) ? DIVZERO : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush)
                    state_next = IDLE;
                else if (cnt == 6'(ITER - 1))
                    state_next = DONE;
            end
            DIVZERO: begin
                stall      = 1'b1;
                state_next = flush ? IDLE : DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            ready <= (state_next == DONE);
            busy  <= (state_next != IDLE);
            if (accept) begin
                cnt   <= '0;
                rem   <= '0;
                quo   <= (signed_div && a[W-1]) ? W'(-a) : a;
                dvs   <= (signed_div && b[W-1]) ? W'(-b) : b;
                a_raw <= a;
                neg_q <= signed_div && (a[W-1] ^ b[W-1]);
                neg_r <= signed_div && a[W-1];
            end else if (state == CALC) begin
                cnt <= cnt + 6'd1;
                rem <= rem_step;
                quo <= quo_step;
            end
            // hi/lo only change on entry to DONE; a flushed divide never gets here.
            if (state_next == DONE) begin
                if (state == DIVZERO) begin
                    hi <= a_raw;
                    lo <= '1;
                end else if (state == CALC) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed divides, a scoreboard of expected hi/lo,
// and a monitor that checks every ready pulse against it.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, signed_div, flush;
    logic [31:0] a, b;
    logic        stall, ready, busy;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] sb[$];
    int          ready_cyc[$];

    div_sequencer #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .flush(flush),
        .a(a), .b(b), .stall(stall), .ready(ready), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst === 1'b0 && ready === 1'b1) begin
            ready_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                e = sb.pop_front();
                check("lo", lo, e[31:0]);
                check("hi", hi, e[63:32]);
            end
        end
    end

    // Issue one divide starting at a negedge; start is held while stalled, dropped after DONE.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic sd,
                         input int lat, input logic fl_done,
                         input logic [31:0] elo, input logic [31:0] ehi);
        sb.push_back({ehi, elo});
        start = 1'b1; a = ta; b = tb_; signed_div = sd;
        for (int c = 0; c <= lat; c++) begin
            if (c == lat) flush = fl_done;
            #1;
            check("stall", 32'(stall), 32'(c < lat));
            check("ready_timing", 32'(ready), 32'(c == lat));
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; flush = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'd100, 32'd7, 1'b0, 33, 1'b0, 32'd14, 32'd2);

        // Flush in CALC cycle 10: no ready, previous result retained.
        start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1; check("flush_pre_stall", 32'(stall), 32'd1);
            @(negedge clk);
        end
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_busy",  32'(busy),  32'd0);
        check("flush_ready", 32'(ready), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_hi_keep", hi, 32'd2);
        check("flush_lo_keep", lo, 32'd14);

        issue(32'hFFFF_FFF9, 32'd2,         1'b1, 33, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 1'b0, 32'h8000_0000, 32'd0);
        issue(32'd7,         32'hFFFF_FFFE, 1'b1, 33, 1'b0, 32'hFFFF_FFFD, 32'd1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 1'b0, 32'd0,         32'h8000_0000);
        issue(32'hFFFF_FFFF, 32'd1,         1'b0, 33, 1'b0, 32'hFFFF_FFFF, 32'd0);
        issue(32'd5,         32'd0,         1'b0, 2,  1'b0, 32'hFFFF_FFFF, 32'd5);
        // Signed divide-by-zero with flush in DONE: ready still pulses.
        issue(32'hFFFF_FFFB, 32'd0,         1'b1, 2,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // start and flush together in IDLE: nothing accepted.
        start = 1'b1; flush = 1'b1; a = 32'd1; b = 32'd1;
        #1; check("sf_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1; check("sf_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Back-to-back: second start in the cycle after DONE.
        issue(32'd100, 32'd7, 1'b0, 33, 1'b0, 32'd14, 32'd2);
        issue(32'd9,   32'd3, 1'b0, 33, 1'b0, 32'd3,  32'd0);
        if (ready_cyc.size() >= 2)
            check("b2b_spacing", 32'(ready_cyc[ready_cyc.size()-1] - ready_cyc[ready_cyc.size()-2]), 32'd34);
        else
            check("b2b_ready_count", 32'(ready_cyc.size()), 32'd2);
        repeat (2) @(negedge clk);

        // Reset at CALC cycle 20 aborts; a fresh start then works.
        start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        check("rstc_stall", 32'(stall), 32'd0);
        check("rstc_busy",  32'(busy),  32'd0);
        check("rstc_ready", 32'(ready), 32'd0);
        check("rstc_hi", hi, 32'd0);
        check("rstc_lo", lo, 32'd0);
        @(negedge clk);
        issue(32'd9, 32'd3, 1'b0, 33, 1'b0, 32'd3, 32'd0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
